// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - F-stage PC register and F/D pipeline register for the five-stage MIPS pipeline
// Optional fetch address-error check enabled by defining IFU_ADDR_CHECK_EN.
module ifu_fetch #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter int          IM_DEPTH = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        d_clear,
    input  logic        branch,
    input  logic [31:0] npc,
    output logic [31:0] im_addr,
    input  logic [31:0] im_rdata,
    output logic [31:0] F_pc,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc8,
    output logic        D_valid
`ifdef IFU_ADDR_CHECK_EN
    ,
    output logic        D_exc_adel
`endif
);

    logic [31:0] next_pc;

    // Memory samples next_pc on the same edge that loads F_pc, so im_rdata tracks F_pc.
    always_comb begin
        if (reset) begin
            next_pc = PC_RESET;
        end else if (stall) begin
            next_pc = F_pc;
        end else if (branch) begin
            next_pc = npc;
        end else begin
            next_pc = F_pc + 32'd4;
        end
    end

    assign im_addr = next_pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            F_pc <= PC_RESET;
        end else begin
            F_pc <= next_pc;
        end
    end

`ifdef IFU_ADDR_CHECK_EN
    localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_DEPTH) << 2);

    logic fetch_fault;
    assign fetch_fault = (F_pc[1:0] != 2'b00) || (F_pc < IM_BASE) || ({1'b0, F_pc} >= IM_LIMIT);
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = IM_BASE ^ 32'(IM_DEPTH);
`endif

    // The delay-slot instruction in F always enters D; a redirect only steers the next fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            D_pc    <= PC_RESET;
            D_instr <= 32'h0;
            D_valid <= 1'b0;
`ifdef IFU_ADDR_CHECK_EN
            D_exc_adel <= 1'b0;
`endif
        end else if (!stall) begin
            if (d_clear) begin
                D_pc    <= PC_RESET;
                D_instr <= 32'h0;
                D_valid <= 1'b0;
`ifdef IFU_ADDR_CHECK_EN
                D_exc_adel <= 1'b0;
`endif
            end else begin
                D_pc    <= F_pc;
                D_valid <= 1'b1;
`ifdef IFU_ADDR_CHECK_EN
                D_instr    <= fetch_fault ? 32'h0 : im_rdata;
                D_exc_adel <= fetch_fault;
`else
                D_instr <= im_rdata;
`endif
            end
        end
    end

    assign D_pc8 = D_pc + 32'd8;

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - directed self-checking bench for ifu_fetch
// Expectations for the IFU_ADDR_CHECK_EN build are selected with the same macro.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        d_clear;
    logic        branch;
    logic [31:0] npc;
    logic [31:0] im_addr;
    logic [31:0] im_rdata;
    logic [31:0] F_pc;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc8;
    logic        D_valid;
`ifdef IFU_ADDR_CHECK_EN
    logic        D_exc_adel;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ifu_fetch dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .d_clear  (d_clear),
        .branch   (branch),
        .npc      (npc),
        .im_addr  (im_addr),
        .im_rdata (im_rdata),
        .F_pc     (F_pc),
        .D_pc     (D_pc),
        .D_instr  (D_instr),
        .D_pc8    (D_pc8),
`ifdef IFU_ADDR_CHECK_EN
        .D_exc_adel (D_exc_adel),
`endif
        .D_valid  (D_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'hCAFE_0000 | {16'h0, a[15:0]};
    endfunction

    always @(posedge clk) im_rdata <= word_at(im_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                           input logic valid);
        check({tag, ".D_pc"}, D_pc, pc);
        check({tag, ".D_instr"}, D_instr, instr);
        check({tag, ".D_valid"}, {31'h0, D_valid}, {31'h0, valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; d_clear = 1'b0; branch = 1'b0; npc = 32'h0;
        step();
        step();
        check("rst.F_pc", F_pc, 32'h3000);
        check("rst.im_addr", im_addr, 32'h3000);
        check("rst.D_pc8", D_pc8, 32'h3008);
        check_d("rst", 32'h3000, 32'h0, 1'b0);
`ifdef IFU_ADDR_CHECK_EN
        check("rst.adel", {31'h0, D_exc_adel}, 32'h0);
`endif

        reset = 1'b0;
        #1;
        check("first.im_addr", im_addr, 32'h3004);
        check("first.im_rdata", im_rdata, 32'hCAFE_3000);
        step();
        check("seq1.F_pc", F_pc, 32'h3004);
        check_d("seq1", 32'h3000, 32'hCAFE_3000, 1'b1);
        check("seq1.D_pc8", D_pc8, 32'h3008);
        step();
        check("seq2.F_pc", F_pc, 32'h3008);
        check_d("seq2", 32'h3004, 32'hCAFE_3004, 1'b1);
        step();
        check("seq3.F_pc", F_pc, 32'h300C);
        check_d("seq3", 32'h3008, 32'hCAFE_3008, 1'b1);

        // branch at 0x3008 sits in D: delay slot 0x300C follows, then target
        branch = 1'b1; npc = 32'h3100;
        step();
        branch = 1'b0;
        check("br.F_pc", F_pc, 32'h3100);
        check_d("br.slot", 32'h300C, 32'hCAFE_300C, 1'b1);
        step();
        check("br.F_pc2", F_pc, 32'h3104);
        check_d("br.tgt", 32'h3100, 32'hCAFE_3100, 1'b1);

        stall = 1'b1; branch = 1'b1; npc = 32'h3200;
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall.F_pc", F_pc, 32'h3104);
            check_d("stall", 32'h3100, 32'hCAFE_3100, 1'b1);
        end
        stall = 1'b0;
        step();
        branch = 1'b0;
        check("unstall.F_pc", F_pc, 32'h3200);
        check_d("unstall", 32'h3104, 32'hCAFE_3104, 1'b1);
        step();
        check("unstall.F_pc2", F_pc, 32'h3204);
        check_d("unstall2", 32'h3200, 32'hCAFE_3200, 1'b1);

        d_clear = 1'b1;
        step();
        d_clear = 1'b0;
        check("clr.F_pc", F_pc, 32'h3208);
        check_d("clr", 32'h3000, 32'h0, 1'b0);
        step();
        check_d("clr.after", 32'h3208, 32'hCAFE_3208, 1'b1);
        stall = 1'b1; d_clear = 1'b1;
        step();
        stall = 1'b0; d_clear = 1'b0;
        check("stclr.F_pc", F_pc, 32'h320C);
        check_d("stclr", 32'h3208, 32'hCAFE_3208, 1'b1);
        step();
        check_d("stclr.after", 32'h320C, 32'hCAFE_320C, 1'b1);

        stall = 1'b1; branch = 1'b1; npc = 32'h4000; reset = 1'b1;
        #1;
        check("rstmid.im_addr", im_addr, 32'h3000);
        step();
        reset = 1'b0; stall = 1'b0; branch = 1'b0;
        check("rstmid.F_pc", F_pc, 32'h3000);
        check_d("rstmid", 32'h3000, 32'h0, 1'b0);
        step();
        check("rstmid.F_pc2", F_pc, 32'h3004);
        check_d("rstmid.after", 32'h3000, 32'hCAFE_3000, 1'b1);

        branch = 1'b1; npc = 32'hFFFF_FFFC;
        step();
        branch = 1'b0;
        check("wrap.F_pc", F_pc, 32'hFFFF_FFFC);
        step();
        check("wrap.F_pc2", F_pc, 32'h0);
        check("wrap.D_pc8", D_pc8, 32'h4);
`ifdef IFU_ADDR_CHECK_EN
        check_d("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1);
        check("wrap.adel", {31'h0, D_exc_adel}, 32'h1);
`else
        check_d("wrap", 32'hFFFF_FFFC, 32'hCAFE_FFFC, 1'b1);
`endif

        branch = 1'b1; npc = 32'h3102;
        step();
        branch = 1'b0;
        check("mis.F_pc", F_pc, 32'h3102);
        step();
        check("mis.F_pc2", F_pc, 32'h3106);
`ifdef IFU_ADDR_CHECK_EN
        check_d("mis", 32'h3102, 32'h0, 1'b1);
        check("mis.adel", {31'h0, D_exc_adel}, 32'h1);
        d_clear = 1'b1;
        step();
        d_clear = 1'b0;
        check("mis.clr.adel", {31'h0, D_exc_adel}, 32'h0);
`else
        check_d("mis", 32'h3102, 32'hCAFE_3102, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
